// File: rtl/seq_gen_fsm.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated with optional
// idle gaps between repetitions, and pulses done after the final bit.
module seq_gen_fsm #(
    parameter int unsigned PAT_W = 5,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [REP_W-1:0] rep_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IdxW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IdxW-1:0] IdxMsb = IdxW'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               x_d, x_valid_d, last_bit_d, busy_d, done_d;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            x         <= x_d;
            x_valid   <= x_valid_d;
            last_bit  <= last_bit_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (start) begin
                    pat_d   = pat_i;
                    rep_d   = (rep_i == '0) ? REP_W'(1) : rep_i;
                    gap_d   = gap_i;
                    idx_d   = IdxMsb;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (idx_q == '0) begin
                    // rep_q counts repetitions still to send, including the current one
                    if (rep_q != '0) rep_d = rep_q - REP_W'(1);
                    if (rep_q > REP_W'(1)) begin
                        idx_d = IdxMsb;
                        if (gap_q != '0) begin
                            gap_cnt_d = gap_q;
                            state_d   = StGap;
                        end
                    end else begin
                        state_d = StFin;
                    end
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    idx_d     = IdxMsb;
                    state_d   = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next-state values so the flops carry them in the same cycle
    always_comb begin
        x_valid_d  = (state_d == StSend);
        x_d        = x_valid_d ? pat_d[idx_d] : 1'b0;
        last_bit_d = x_valid_d && (idx_d == '0);
        busy_d     = (state_d == StSend) || (state_d == StGap);
        done_d     = (state_d == StFin);
    end

endmodule
